// File: rtl/seg7_pkg.sv
// seg7_pkg: segment table and index sizing rule shared by the seven-segment driver
// Contents: SEG_TABLE (hex digit -> active-high {a,b,c,d,e,f,g}), idx_width(n) = max(1, clog2(n))
package seg7_pkg;
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational hex nibble to seven-segment decoder
// Ports: nibble (4-bit hex digit in), seg (7 active-high segments out, bit 6 = a ... bit 0 = g)
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nibble];
endmodule

// File: rtl/seg7_mux_driver.sv
// seg7_mux_driver: time-multiplexed seven-segment display driver with tear-free shadow update
// Ports: clk, rst (sync, active-high), enable (0 blanks outputs), load (captures value/dp_mask),
//        value (nibble i = digit i), dp_mask (bit i = dp of digit i), an (one-hot digit select),
//        a_to_g (segments, bit 6 = a), dp, pending (loaded value awaiting commit),
//        frame_done (one-cycle pulse after each frame wrap)
// Option: define SEG7_LZ_BLANK_EN to darken digits above the most significant nonzero digit
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                a_to_g,
    output logic                      dp,
    output logic                      pending,
    output logic                      frame_done
);
    localparam int   IDX_W = idx_width(NUM_DIGITS);
    localparam int   CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic INV   = 1'(ACTIVE_LOW != 0);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   an_q;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic                    tick;
    logic                    wrap;
    logic                    lit;
    logic [3:0]              nib;
    logic [6:0]              seg_hex;

    assign tick = cnt == CNT_W'(CLK_DIV - 1);
    assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));
    assign nib  = disp_val[4*idx +: 4];

    seg7_hex_decode u_dec (
        .nibble (nib),
        .seg    (seg_hex)
    );

`ifdef SEG7_LZ_BLANK_EN
    // A digit stays lit if it or any higher digit is nonzero; digit 0 always lit
    logic [NUM_DIGITS-1:0] vis;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_vis
        assign vis[i] = (i == 0) || (|disp_val[4*NUM_DIGITS-1:4*i]);
    end
    assign lit = vis[idx];
`else
    assign lit = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            an_q       <= '0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= wrap ? '0 : idx + 1'b1;
            // Commit only at the frame boundary so a frame never mixes old and new digits
            if (wrap && pending) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
                pending  <= 1'b0;
            end
            // A load in the commit cycle lands after the commit and re-arms pending
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_mask;
                pending    <= 1'b1;
            end
            frame_done <= wrap;
            an_q       <= (enable && lit) ? NUM_DIGITS'(1) << idx : '0;
            seg_q      <= enable ? seg_hex : '0;
            dp_q       <= enable && lit && disp_dp[idx];
        end
    end

    assign an     = an_q ^ {NUM_DIGITS{INV}};
    assign a_to_g = seg_q ^ {7{INV}};
    assign dp     = dp_q ^ INV;
endmodule
